debug_uart_wb_master: RTL and testbench

- Command sequencer for the management core debug path. It turns a byte stream from the debug UART receiver into Wishbone master transactions and returns read data as a byte stream to the UART transmitter.
- Sits between the debug UART (enabled when the debug input is high) and the debug Wishbone arbiter port, so a host can read and write SoC registers and RAM without firmware running.

---
 rtl/debug_uart_wb_master.sv | 219 +++++++++++++++++++++
 tb/tb_debug_uart_wb_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_wb_master.sv
// Debug command bridge: parses CMD/LEN/ADDR/DATA bytes from the debug UART into Wishbone cycles.
// Latency: bus cycle opens one cycle after the last header/data byte; read data is on tx one cycle after ack.
// Backpressure: each tx byte is held until tx_ready; rx bytes that arrive during bus or send phases are dropped.
module debug_uart_wb_master #(
  parameter int unsigned WB_TIMEOUT = 1024,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        debug_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy,
  output logic        err_flag
);

  localparam int unsigned TMAX = (WB_TIMEOUT > RX_TIMEOUT) ? WB_TIMEOUT : RX_TIMEOUT;
  localparam int TW = $clog2(TMAX);
  localparam logic [TW-1:0] WB_LAST = TW'(WB_TIMEOUT - 1);
  localparam logic [TW-1:0] RX_LAST = TW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_SEND} state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    byte_q, byte_d;
  logic [29:0]   adr_q, adr_d;
  logic [31:0]   data_q, data_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic          tx_vld_q, tx_vld_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic last_word;
  logic bus_done;
  logic bus_bad;

  assign last_word = (cnt_q + 8'd1) == len_q;
  // An error wins over a simultaneous ack; a timeout only counts when no ack arrived.
  assign bus_bad   = wb_err_i | (~wb_ack_i & (tmo_q == WB_LAST));
  assign bus_done  = wb_ack_i | bus_bad;

  // Next-state logic for the parser, bus sequencer and tx byte shifter.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    adr_d    = adr_q;
    data_d   = data_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    tx_vld_d = tx_vld_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (debug_en && rx_valid && (rx_data == 8'h01 || rx_data == 8'h02)) begin
          state_d = S_LEN;
          is_wr_d = (rx_data == 8'h01);
          err_d   = 1'b0;
        end
      end
      S_LEN, S_ADDR, S_WDATA: begin
        if (!debug_en) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          tmo_d = '0;
          if (state_q == S_LEN) begin
            len_d   = rx_data;
            byte_d  = 2'd0;
            state_d = S_ADDR;
          end else if (state_q == S_ADDR) begin
            adr_d  = {adr_q[21:0], rx_data};
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              cnt_d  = 8'd0;
              byte_d = 2'd0;
              if (len_q == 8'd0) begin
                state_d = S_IDLE;
              end else if (is_wr_q) begin
                state_d = S_WDATA;
              end else begin
                state_d = S_WB_RD;
                cyc_d   = 1'b1;
              end
            end
          end else begin
            data_d = {data_q[23:0], rx_data};
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              state_d = S_WB_WR;
              cyc_d   = 1'b1;
              we_d    = 1'b1;
            end
          end
        end else if (tmo_q == RX_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB_WR: begin
        if (bus_done) begin
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          tmo_d  = '0;
          err_d  = err_q | bus_bad;
          adr_d  = adr_q + 30'd1;
          cnt_d  = cnt_q + 8'd1;
          byte_d = 2'd0;
          state_d = (!debug_en || last_word) ? S_IDLE : S_WDATA;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB_RD: begin
        if (bus_done) begin
          cyc_d  = 1'b0;
          tmo_d  = '0;
          err_d  = err_q | bus_bad;
          data_d = bus_bad ? 32'hFFFF_FFFF : wb_dat_i;
          byte_d = 2'd0;
          if (debug_en) begin
            state_d  = S_SEND;
            tx_vld_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SEND: begin
        if (!debug_en) begin
          state_d  = S_IDLE;
          tx_vld_d = 1'b0;
        end else if (tx_vld_q && tx_ready) begin
          data_d = {data_q[23:0], 8'h00};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            tx_vld_d = 1'b0;
            adr_d    = adr_q + 30'd1;
            cnt_d    = cnt_q + 8'd1;
            tmo_d    = '0;
            if (last_word) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_WB_RD;
              cyc_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      byte_q   <= 2'd0;
      adr_q    <= 30'd0;
      data_q   <= 32'd0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      adr_q    <= adr_d;
      data_q   <= data_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      tx_vld_q <= tx_vld_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // tx_valid is gated by debug_en so it falls in the same cycle the bridge is disabled.
  assign tx_data  = data_q[31:24];
  assign tx_valid = tx_vld_q & debug_en;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = data_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy     = (state_q != S_IDLE);
  assign err_flag = err_q;

endmodule

// File: tb/tb_debug_uart_wb_master.sv
// Directed bench for debug_uart_wb_master with short timeouts.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Wishbone slave responses are driven by hand in each step.
module tb_debug_uart_wb_master;

  localparam int unsigned WB_TMO = 16;
  localparam int unsigned RX_TMO = 64;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        debug_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [29:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        busy;
  logic        err_flag;

  int vecs = 0;
  int errs = 0;

  debug_uart_wb_master #(.WB_TIMEOUT(WB_TMO), .RX_TIMEOUT(RX_TMO)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .debug_en(debug_en),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy), .err_flag(err_flag)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rx strobe spanning exactly one rising edge; returns on the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge core_clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] adr);
    send_byte(cmd);
    send_byte(len);
    send_byte(adr[31:24]);
    send_byte(adr[23:16]);
    send_byte(adr[15:8]);
    send_byte(adr[7:0]);
  endtask

  task automatic ack_with(input logic [31:0] d);
    wb_dat_i = d;
    wb_ack_i = 1'b1;
    @(negedge core_clk);
    wb_ack_i = 1'b0;
  endtask

  // Collect four tx bytes with a random tx_ready pattern, bounded by a cycle budget.
  task automatic get_word(output logic [31:0] w, output int n);
    n = 0;
    w = 32'd0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        w = {w[23:0], tx_data};
        n++;
      end
      @(negedge core_clk);
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          n;
    int          cyc_seen;

    core_rst = 1'b1; debug_en = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    tx_ready = 1'b0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(negedge core_clk);
    chk("rst_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_valid, busy, err_flag}, 32'h0);
    chk("rst_adr", {2'b00, wb_adr_o}, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    core_rst = 1'b0;
    @(negedge core_clk);

    // Single-word write to 0x0001000.
    send_hdr(8'h01, 8'h01, 32'h0000_1000);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    chk("wr_cyc_before_last", {31'd0, wb_cyc_o}, 32'd0);
    send_byte(8'hEF);
    chk("wr_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd7);
    chk("wr_adr", {2'b00, wb_adr_o}, 32'h0000_1000);
    chk("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
    chk("wr_sel", {28'd0, wb_sel_o}, 32'hF);
    ack_with(32'h0);
    chk("wr_cyc_after_ack", {31'd0, wb_cyc_o}, 32'd0);
    chk("wr_busy_after_ack", {31'd0, busy}, 32'd0);

    // Two-word read at 0x20.
    send_hdr(8'h02, 8'h02, 32'h0000_0020);
    chk("rd0_cyc_we", {30'd0, wb_cyc_o, wb_we_o}, 32'd2);
    chk("rd0_adr", {2'b00, wb_adr_o}, 32'h20);
    ack_with(32'h1234_5678);
    chk("rd0_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("rd0_first_byte", {23'd0, tx_valid, tx_data}, 32'h112);
    get_word(w, n);
    chk("rd0_nbytes", n, 32'd4);
    chk("rd0_word", w, 32'h1234_5678);
    chk("rd1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("rd1_adr", {2'b00, wb_adr_o}, 32'h21);
    ack_with(32'hCAFE_F00D);
    get_word(w, n);
    chk("rd1_word", w, 32'hCAFE_F00D);
    chk("rd_busy_end", {31'd0, busy}, 32'd0);

    // Read against a silent slave: timeout, all-ones data, sticky error.
    send_hdr(8'h02, 8'h01, 32'h0000_0040);
    n = 0;
    while (wb_cyc_o && n < 100) begin
      n++;
      @(negedge core_clk);
    end
    chk("tmo_cyc_cycles", n, WB_TMO);
    chk("tmo_err_flag", {31'd0, err_flag}, 32'd1);
    get_word(w, n);
    chk("tmo_word", w, 32'hFFFF_FFFF);
    chk("tmo_busy_end", {30'd0, busy, err_flag}, 32'd1);
    send_byte(8'h02);
    chk("tmo_err_clear", {30'd0, busy, err_flag}, 32'd2);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("len0_rd_idle", {31'd0, busy}, 32'd0);

    // RX silence mid-header returns to IDLE without a bus cycle.
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    n = 0;
    cyc_seen = 0;
    while (busy && n < 300) begin
      if (wb_cyc_o) cyc_seen++;
      n++;
      @(negedge core_clk);
    end
    chk("rxtmo_cycles", n, RX_TMO);
    chk("rxtmo_no_cyc", cyc_seen, 32'd0);
    send_hdr(8'h01, 8'h01, 32'h0000_0008);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("rxtmo_next_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("rxtmo_next_adr", {2'b00, wb_adr_o}, 32'h8);
    chk("rxtmo_next_dat", wb_dat_o, 32'h1122_3344);
    ack_with(32'h0);

    // LEN=0 frame and a stray byte.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("len0_busy_before_last", {31'd0, busy}, 32'd1);
    send_byte(8'h04);
    chk("len0_idle", {30'd0, busy, wb_cyc_o}, 32'd0);
    send_byte(8'h55);
    chk("stray_ignored", {31'd0, busy}, 32'd0);

    // debug_en low blocks CMD in IDLE.
    debug_en = 1'b0;
    send_byte(8'h01);
    chk("dis_idle_block", {31'd0, busy}, 32'd0);
    debug_en = 1'b1;

    // debug_en dropped while a read cycle is open: cycle finishes, then IDLE.
    send_hdr(8'h02, 8'h02, 32'h0000_0030);
    debug_en = 1'b0;
    repeat (3) @(negedge core_clk);
    chk("dis_cyc_held", {30'd0, wb_cyc_o, busy}, 32'd3);
    ack_with(32'hA5A5_A5A5);
    chk("dis_after_ack", {29'd0, wb_cyc_o, busy, tx_valid}, 32'd0);
    debug_en = 1'b1;

    // debug_en dropped while a byte is waiting on tx.
    send_hdr(8'h02, 8'h01, 32'h0000_0050);
    ack_with(32'h9876_5432);
    chk("send_vld", {23'd0, tx_valid, tx_data}, 32'h198);
    debug_en = 1'b0;
    #1;
    chk("send_vld_drop", {31'd0, tx_valid}, 32'd0);
    @(negedge core_clk);
    chk("send_dis_idle", {31'd0, busy}, 32'd0);
    debug_en = 1'b1;

    // Reset in the middle of a write cycle.
    send_hdr(8'h01, 8'h01, 32'h0000_0100);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("mid_rst_pre_cyc", {31'd0, wb_cyc_o}, 32'd1);
    core_rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_valid, busy, err_flag}, 32'h0);
    chk("mid_rst_adr_dat", {2'b00, wb_adr_o} | wb_dat_o, 32'h0);
    @(negedge core_clk);
    core_rst = 1'b0;
    @(negedge core_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
